// File: rtl/float_discriminant_distributor.sv
// FP64 discriminant (b*b - 4*a*c) spread round-robin over N_UNITS single-cycle units.
// Results return in acceptance order through one output register with ready/valid.

module float_discriminant #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err
);
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  function automatic logic is_special(input logic [63:0] x);
    return x[62:52] == 11'h7FF;
  endfunction

  // Subnormals are flushed to zero on input and output.
  function automatic logic is_zero(input logic [63:0] x);
    return x[62:52] == 11'h000;
  endfunction

  function automatic logic [63:0] pack(input logic s, input logic signed [13:0] e,
                                       input logic [52:0] m, input logic g, input logic st);
    logic [53:0]        mr;
    logic signed [13:0] er;
    mr = {1'b0, m} + {53'b0, g & (st | m[0])};
    er = e;
    if (mr[53]) begin
      mr = mr >> 1;
      er = er + 14'sd1;
    end
    if (er >= 14'sd2047) return {s, 11'h7FF, 52'b0};
    if (er <= 14'sd0) return {s, 63'b0};
    return {s, er[10:0], mr[51:0]};
  endfunction

  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
    logic               s;
    logic [105:0]       p;
    logic signed [13:0] e;
    s = x[63] ^ y[63];
    if (is_zero(x) || is_zero(y)) return {s, 63'b0};
    p = {53'b0, 1'b1, x[51:0]} * {53'b0, 1'b1, y[51:0]};
    e = $signed({3'b0, x[62:52]}) + $signed({3'b0, y[62:52]}) - 14'sd1023;
    if (p[105]) return pack(s, e + 14'sd1, p[105:53], p[52], |p[51:0]);
    return pack(s, e, p[104:52], p[51], |p[50:0]);
  endfunction

  function automatic logic [63:0] scale4(input logic [63:0] x);
    logic [11:0] e;
    if (is_zero(x) || is_special(x)) return x;
    e = {1'b0, x[62:52]} + 12'd2;
    if (e >= 12'd2047) return {x[63], 11'h7FF, 52'b0};
    return {x[63], e[10:0], x[51:0]};
  endfunction

  function automatic logic [63:0] fsub(input logic [63:0] x, input logic [63:0] y);
    logic [63:0]        yn, big, sml;
    logic [55:0]        mb, ms, sh, mask;
    logic [56:0]        sum;
    logic [10:0]        d;
    logic signed [13:0] e;
    int                 lz;
    yn = {~y[63], y[62:0]};
    if (is_special(x) && is_special(yn) && (x[63] != yn[63])) return QNAN;
    if (is_special(x)) return x;
    if (is_special(yn)) return yn;
    if (is_zero(x) && is_zero(yn)) return {x[63] & yn[63], 63'b0};
    if (is_zero(x)) return yn;
    if (is_zero(yn)) return x;
    if (x[62:0] >= yn[62:0]) begin
      big = x;
      sml = yn;
    end else begin
      big = yn;
      sml = x;
    end
    d  = big[62:52] - sml[62:52];
    mb = {1'b1, big[51:0], 3'b0};
    ms = {1'b1, sml[51:0], 3'b0};
    if (d >= 11'd56) begin
      sh = {55'b0, 1'b1};
    end else begin
      mask = (56'd1 << d) - 56'd1;
      sh   = (ms >> d) | {55'b0, |(ms & mask)};
    end
    e = $signed({3'b0, big[62:52]});
    if (big[63] == sml[63]) begin
      sum = {1'b0, mb} + {1'b0, sh};
      if (sum[56]) begin
        sum = {1'b0, sum[56:2], sum[1] | sum[0]};
        e   = e + 14'sd1;
      end
    end else begin
      sum = {1'b0, mb} - {1'b0, sh};
      if (sum == 57'd0) return 64'd0;
      lz = 0;
      for (int i = 0; i < 56; i++) if (sum[i]) lz = 55 - i;
      sum = sum << lz;
      e   = e - 14'(lz);
    end
    return pack(big[63], e, sum[55:3], sum[2], |sum[1:0]);
  endfunction

  logic [63:0] bb, ac4, disc;
  logic        bad;
  logic        res_vld_q;
  logic [63:0] res_q;
  logic        neg_q, err_q;

  always_comb begin
    bad  = is_special(a) || is_special(b) || is_special(c);
    bb   = fmul(b, b);
    ac4  = scale4(fmul(a, c));
    disc = bad ? QNAN : fsub(bb, ac4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      res_vld_q <= arg_vld;
      if (arg_vld) begin
        res_q <= disc;
        neg_q <= disc[63] && !bad && (disc[62:0] != 63'd0);
        err_q <= bad;
      end
    end
  end

  assign res_vld      = res_vld_q;
  assign res          = res_q;
  assign res_negative = neg_q;
  assign err          = err_q;
endmodule

module float_discriminant_distributor #(
  parameter int FLEN    = 64,
  parameter int N_UNITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arg_vld,
  input  logic [FLEN-1:0]                a,
  input  logic [FLEN-1:0]                b,
  input  logic [FLEN-1:0]                c,
  output logic                           busy,
  output logic                           res_vld,
  output logic [FLEN-1:0]                res,
  output logic                           res_negative,
  output logic                           err,
  input  logic                           res_rdy,
  output logic [$clog2(N_UNITS+2)-1:0]   in_flight
);
  localparam int PW = $clog2(N_UNITS);
  localparam int CW = $clog2(N_UNITS+2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} slot_e;

  slot_e           slot_q    [N_UNITS];
  slot_e           slot_d    [N_UNITS];
  logic [FLEN-1:0] buf_res_q [N_UNITS];
  logic [FLEN-1:0] buf_res_d [N_UNITS];
  logic            buf_neg_q [N_UNITS];
  logic            buf_neg_d [N_UNITS];
  logic            buf_err_q [N_UNITS];
  logic            buf_err_d [N_UNITS];
  logic [FLEN-1:0] u_res     [N_UNITS];
  logic [N_UNITS-1:0] u_arg_vld, u_res_vld, u_neg, u_err;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            res_vld_q, res_vld_d;
  logic [FLEN-1:0] res_q, res_d;
  logic            neg_q, neg_d, err_q, err_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic            accept, load, deliver;
  logic            unit_rst;

  assign unit_rst = ~rst_n;

  for (genvar i = 0; i < N_UNITS; i++) begin : g_unit
    float_discriminant #(.FLEN(FLEN)) u_disc (
      .clk          (clk),
      .rst          (unit_rst),
      .arg_vld      (u_arg_vld[i]),
      .a            (a),
      .b            (b),
      .c            (c),
      .res_vld      (u_res_vld[i]),
      .res          (u_res[i]),
      .res_negative (u_neg[i]),
      .err          (u_err[i])
    );
  end

  always_comb begin
    busy    = (slot_q[wr_ptr_q] != S_IDLE);
    accept  = arg_vld && !busy;
    load    = (slot_q[rd_ptr_q] == S_DONE) && (!res_vld_q || res_rdy);
    deliver = res_vld_q && res_rdy;

    u_arg_vld = '0;
    slot_d    = slot_q;
    buf_res_d = buf_res_q;
    buf_neg_d = buf_neg_q;
    buf_err_d = buf_err_q;
    // Accept needs IDLE and unload needs DONE, so both may hit the same index safely.
    for (int i = 0; i < N_UNITS; i++) begin
      if (slot_q[i] == S_RUN && u_res_vld[i]) begin
        slot_d[i]    = S_DONE;
        buf_res_d[i] = u_res[i];
        buf_neg_d[i] = u_neg[i];
        buf_err_d[i] = u_err[i];
      end
      if (accept && wr_ptr_q == PW'(i)) begin
        slot_d[i]    = S_RUN;
        u_arg_vld[i] = 1'b1;
      end
      if (load && rd_ptr_q == PW'(i)) slot_d[i] = S_IDLE;
    end

    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + PW'(1) : rd_ptr_q;

    res_vld_d = res_vld_q;
    res_d     = res_q;
    neg_d     = neg_q;
    err_d     = err_q;
    if (load) begin
      res_vld_d = 1'b1;
      res_d     = buf_res_q[rd_ptr_q];
      neg_d     = buf_neg_q[rd_ptr_q];
      err_d     = buf_err_q[rd_ptr_q];
    end else if (deliver) begin
      res_vld_d = 1'b0;
    end

    in_flight_d = in_flight_q;
    if (accept && !deliver) in_flight_d = in_flight_q + CW'(1);
    else if (!accept && deliver) in_flight_d = in_flight_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_UNITS; i++) begin
        slot_q[i]    <= S_IDLE;
        buf_res_q[i] <= '0;
        buf_neg_q[i] <= 1'b0;
        buf_err_q[i] <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      in_flight_q <= '0;
    end else begin
      slot_q      <= slot_d;
      buf_res_q   <= buf_res_d;
      buf_neg_q   <= buf_neg_d;
      buf_err_q   <= buf_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      res_vld_q   <= res_vld_d;
      res_q       <= res_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign res_vld      = res_vld_q;
  assign res          = res_q;
  assign res_negative = neg_q;
  assign err          = err_q;
  assign in_flight    = in_flight_q;
endmodule

// File: tb/tb_float_discriminant_distributor.sv
// Scoreboard bench for float_discriminant_distributor: expected results are queued at
// accept time from a real-arithmetic model and compared at delivery.

module tb_float_discriminant_distributor;
  localparam int FLEN    = 64;
  localparam int N_UNITS = 4;
  localparam logic [63:0] NAN_B = 64'h7FF8_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst_n, arg_vld, res_rdy;
  logic [FLEN-1:0] a, b, c;
  logic            busy, res_vld, res_negative, err;
  logic [FLEN-1:0] res;
  logic [$clog2(N_UNITS+2)-1:0] in_flight;

  float_discriminant_distributor #(.FLEN(FLEN), .N_UNITS(N_UNITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arg_vld      (arg_vld),
    .a            (a),
    .b            (b),
    .c            (c),
    .busy         (busy),
    .res_vld      (res_vld),
    .res          (res),
    .res_negative (res_negative),
    .err          (err),
    .res_rdy      (res_rdy),
    .in_flight    (in_flight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        neg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic acc_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] ra, input logic [63:0] rb,
                                 input logic [63:0] rc);
    exp_t e;
    real  r;
    e.err = (ra[62:52] == 11'h7FF) || (rb[62:52] == 11'h7FF) || (rc[62:52] == 11'h7FF);
    if (e.err) begin
      e.res = NAN_B;
      e.neg = 1'b0;
    end else begin
      r = $bitstoreal(rb) * $bitstoreal(rb) - 4.0 * $bitstoreal(ra) * $bitstoreal(rc);
      e.res = $realtobits(r);
      e.neg = (r < 0.0);
    end
    return e;
  endfunction

  function automatic logic [63:0] rb2(input real r);
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] rnd_val();
    return $realtobits(real'(int'($urandom_range(0, 64)) - 32) / 4.0);
  endfunction

  // One clock: decide accept/delivery on settled low-phase values, then cross the edge.
  task automatic tick();
    exp_t e;
    #1;
    acc_last = arg_vld && !busy;
    if (res_vld && res_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_depth", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        if (!e.err) chk("res", res, e.res);
        chk("res_negative", {63'b0, res_negative}, {63'b0, e.neg});
        chk("err", {63'b0, err}, {63'b0, e.err});
      end
    end
    if (acc_last) sb.push_back(model(a, b, c));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] ra, input logic [63:0] rb, input logic [63:0] rc);
    int n;
    n = 0;
    arg_vld = 1'b1;
    a = ra;
    b = rb;
    c = rc;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 50);
    chk("send_accept", {63'b0, acc_last}, 64'd1);
    arg_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    while ((sb.size() != 0 || res_vld) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_sb", 64'(sb.size()), 64'd0);
    chk("drain_vld", {63'b0, res_vld}, 64'd0);
    chk("drain_in_flight", 64'(in_flight), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   idx, n_acc;
    logic busy_seen, stale;
    logic [63:0] fa [6];
    logic [63:0] fb [6];
    logic [63:0] fc [6];

    rst_n = 1'b0; arg_vld = 1'b0; res_rdy = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    chk("rst_res_vld", {63'b0, res_vld}, 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_neg", {63'b0, res_negative}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_in_flight", 64'(in_flight), 64'd0);
    rst_n = 1'b1;

    // Single triple, accepted on the first edge after reset, with latency checks.
    res_rdy = 1'b1;
    send(rb2(1.0), rb2(4.0), rb2(2.0));
    chk("lat_e0", {63'b0, res_vld}, 64'd0);
    tick();
    chk("lat_e1", {63'b0, res_vld}, 64'd0);
    tick();
    chk("lat_e2", {63'b0, res_vld}, 64'd1);
    chk("single_res", res, 64'h4020_0000_0000_0000);
    drain();

    send(rb2(1.0), rb2(2.0), rb2(5.0));
    tick();
    tick();
    chk("neg_res", res, 64'hC030_0000_0000_0000);
    chk("neg_flag", {63'b0, res_negative}, 64'd1);
    drain();

    send(rb2(1.0), rb2(2.0), rb2(1.0));
    send(rb2(1.0), NAN_B, rb2(1.0));
    send(rb2(2.0), rb2(5.0), rb2(1.0));
    drain();

    // Backpressure fill: output register plus four slots, sixth triple refused.
    fa = '{rb2(1.0), rb2(2.0), rb2(0.5), rb2(-1.0), rb2(3.0), rb2(1.0)};
    fb = '{rb2(3.0), rb2(1.0), rb2(2.0), rb2(3.0), rb2(0.0), rb2(1.0)};
    fc = '{rb2(1.0), rb2(1.0), rb2(2.0), rb2(2.0), rb2(1.0), rb2(1.0)};
    res_rdy = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      arg_vld = 1'b1;
      a = fa[idx]; b = fb[idx]; c = fc[idx];
      tick();
      if (acc_last) idx++;
      if (idx > 5) idx = 5;
    end
    chk("fill_accepted", 64'(sb.size()), 64'd5);
    chk("fill_busy", {63'b0, busy}, 64'd1);
    chk("fill_in_flight", 64'(in_flight), 64'd5);
    arg_vld = 1'b0;
    res_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fill_drain_vld", {63'b0, res_vld}, 64'd1);
      tick();
    end
    chk("fill_end_vld", {63'b0, res_vld}, 64'd0);
    chk("fill_end_in_flight", 64'(in_flight), 64'd0);

    // Streaming: 3*N_UNITS back-to-back triples with the consumer always ready.
    busy_seen = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 3 * N_UNITS; i++) begin
      arg_vld = 1'b1;
      a = rnd_val(); b = rnd_val(); c = rnd_val();
      busy_seen |= busy;
      tick();
      if (acc_last) n_acc++;
    end
    arg_vld = 1'b0;
    chk("stream_busy", {63'b0, busy_seen}, 64'd0);
    chk("stream_accepts", 64'(n_acc), 64'(3 * N_UNITS));
    drain();

    // Reset with three triples in flight.
    res_rdy = 1'b0;
    send(rb2(1.0), rb2(3.0), rb2(1.0));
    send(rb2(2.0), rb2(3.0), rb2(1.0));
    send(rb2(1.0), rb2(5.0), rb2(2.0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_vld", {63'b0, res_vld}, 64'd0);
    chk("mid_rst_res", res, 64'd0);
    chk("mid_rst_in_flight", 64'(in_flight), 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    res_rdy = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 6; k++) begin
      stale |= res_vld;
      tick();
    end
    chk("post_rst_stale", {63'b0, stale}, 64'd0);
    send(rb2(2.0), rb2(6.0), rb2(3.0));
    drain();

    // Random offers and random backpressure; in_flight tracks the scoreboard depth.
    idx = 0;
    for (int cyc = 0; cyc < 1000 && idx < 40; cyc++) begin
      arg_vld = ($urandom_range(0, 3) != 0);
      res_rdy = ($urandom_range(0, 2) != 0);
      a = rnd_val(); b = rnd_val(); c = rnd_val();
      if ($urandom_range(0, 15) == 0) b = NAN_B;
      tick();
      if (acc_last) idx++;
      chk("rand_in_flight", 64'(in_flight), 64'(sb.size()));
    end
    chk("rand_accepts", 64'(idx), 64'd40);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
